// File: rtl/mips_hazard_pkg.sv
// Shared types for the MIPS hazard/forwarding controller: scoreboard entry, FSM states, $0 constant.
package mips_hazard_pkg;

  localparam int PKG_REG_AW = 5;
  localparam logic [PKG_REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  is_load;
    logic [PKG_REG_AW-1:0] dst;
  } stage_info_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_FLUSH    = 2'd2
  } haz_state_e;

  localparam stage_info_t STAGE_EMPTY = '{valid: 1'b0, wr: 1'b0, is_load: 1'b0, dst: '0};

  // A producer is a forwarding source only if it really writes a non-$0 register.
  function automatic logic stage_hit(input stage_info_t e, input logic [PKG_REG_AW-1:0] src);
    return e.valid && e.wr && (src != REG_ZERO) && (e.dst == src);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow scoreboard: EX/MEM/WB destination info shifted every cycle, with source-match outputs for ID.
module hazard_scoreboard
  import mips_hazard_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  stage_info_t           i_id_entry,
  input  logic [PKG_REG_AW-1:0] i_rs,
  input  logic [PKG_REG_AW-1:0] i_rt,
  input  logic                  i_uses_rt,
  output logic                  o_ex_is_load,
  output logic                  o_rs_ex_hit,
  output logic                  o_rs_mem_hit,
  output logic                  o_rt_ex_hit,
  output logic                  o_rt_mem_hit,
  output stage_info_t           o_wb_entry
);

  stage_info_t r_ex;
  stage_info_t r_mem;
  stage_info_t r_wb;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex  <= STAGE_EMPTY;
      r_mem <= STAGE_EMPTY;
      r_wb  <= STAGE_EMPTY;
    end else begin
      r_ex  <= i_id_entry;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  assign o_ex_is_load = r_ex.valid && r_ex.is_load;
  assign o_rs_ex_hit  = stage_hit(r_ex, i_rs);
  assign o_rs_mem_hit = stage_hit(r_mem, i_rs);
  assign o_rt_ex_hit  = i_uses_rt && stage_hit(r_ex, i_rt);
  assign o_rt_mem_hit = i_uses_rt && stage_hit(r_mem, i_rt);
  // WB producers are covered by register-file write-before-read; exported for visibility only.
  assign o_wb_entry   = r_wb;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline (load-use stall, jump/branch flush).
// Optional perf counters (stall_count/flush_count) enabled by defining HAZ_PERF_CNT_EN.
//
//   state       | meaning
//   ST_RUN      | normal issue; load-use detect, jump/branch flush
//   ST_LD_STALL | extra load-use bubble cycles (down-counter to terminal count)
//   ST_FLUSH    | cycle after a taken-branch flush; behaves like ST_RUN
module hazard_forward_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int REG_AW            = PKG_REG_AW,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_RegDst,
  input  logic              i_id_RegWr,
  input  logic              i_id_MemToReg,
  input  logic              i_id_uses_rt,
  input  logic              i_id_Jump,
  input  logic              i_ex_branch_taken,
  output logic              o_ex_forward_a,
  output logic              o_ex_forward_b,
  output logic              o_mem_forward_a,
  output logic              o_mem_forward_b,
  output logic              o_pc_hold,
  output logic              o_ifid_hold,
  output logic              o_idex_bubble,
  output logic              o_ifid_flush
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_stall_count,
  output logic [CNT_W-1:0]  o_flush_count
`endif
);

  localparam logic [1:0] STALL_LD = 2'(LOAD_STALL_CYCLES - 1);

  haz_state_e        r_state;
  haz_state_e        w_state_nxt;
  logic [1:0]        r_stall_cnt;
  logic [1:0]        w_stall_cnt_nxt;

  stage_info_t       w_id_entry;
  stage_info_t       w_wb_entry;
  logic [REG_AW-1:0] w_id_dst;
  logic              w_ex_is_load;
  logic              w_rs_ex_hit;
  logic              w_rs_mem_hit;
  logic              w_rt_ex_hit;
  logic              w_rt_mem_hit;
  logic              w_load_use;

  logic              w_stall;
  logic              w_bubble;
  logic              w_flush;
  logic              w_pc_hold;
  logic              w_idex_bubble;
  logic              w_ifid_flush;

  logic              r_ex_fwd_a;
  logic              r_ex_fwd_b;
  logic              r_mem_fwd_a;
  logic              r_mem_fwd_b;

  assign w_id_dst = i_id_RegDst ? i_id_rd : i_id_rt;

  always_comb begin
    w_id_entry         = STAGE_EMPTY;
    w_id_entry.valid   = !(w_idex_bubble || w_ifid_flush);
    w_id_entry.wr      = i_id_RegWr && (w_id_dst != REG_ZERO);
    w_id_entry.is_load = i_id_MemToReg;
    w_id_entry.dst     = w_id_dst;
  end

  hazard_scoreboard u_scoreboard (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_id_entry   (w_id_entry),
    .i_rs         (i_id_rs),
    .i_rt         (i_id_rt),
    .i_uses_rt    (i_id_uses_rt),
    .o_ex_is_load (w_ex_is_load),
    .o_rs_ex_hit  (w_rs_ex_hit),
    .o_rs_mem_hit (w_rs_mem_hit),
    .o_rt_ex_hit  (w_rt_ex_hit),
    .o_rt_mem_hit (w_rt_mem_hit),
    .o_wb_entry   (w_wb_entry)
  );

  assign w_load_use = w_ex_is_load && (w_rs_ex_hit || w_rt_ex_hit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  // A taken branch always wins: it squashes the stalled consumer, so any pending stall is dropped.
  always_comb begin
    w_state_nxt     = ST_RUN;
    w_stall_cnt_nxt = r_stall_cnt;
    w_stall         = 1'b0;
    w_bubble        = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      ST_LD_STALL: begin
        if (i_ex_branch_taken) begin
          w_flush         = 1'b1;
          w_bubble        = 1'b1;
          w_state_nxt     = ST_FLUSH;
          w_stall_cnt_nxt = '0;
        end else begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          if (r_stall_cnt <= 2'd1) begin
            w_state_nxt     = ST_RUN;
            w_stall_cnt_nxt = '0;
          end else begin
            w_state_nxt     = ST_LD_STALL;
            w_stall_cnt_nxt = r_stall_cnt - 2'd1;
          end
        end
      end
      default: begin
        if (i_ex_branch_taken) begin
          w_flush         = 1'b1;
          w_bubble        = 1'b1;
          w_state_nxt     = ST_FLUSH;
          w_stall_cnt_nxt = '0;
        end else if (w_load_use) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_state_nxt     = ST_LD_STALL;
            w_stall_cnt_nxt = STALL_LD;
          end
        end else if (i_id_Jump) begin
          w_flush = 1'b1;
        end
      end
    endcase
  end

  // Combinational controls are forced low while reset is asserted, regardless of inputs.
  assign w_pc_hold     = i_rst_n && w_stall;
  assign w_idex_bubble = i_rst_n && w_bubble;
  assign w_ifid_flush  = i_rst_n && w_flush;

  // Selects are for the instruction entering EX; a bubble carries no operands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_fwd_a  <= 1'b0;
      r_ex_fwd_b  <= 1'b0;
      r_mem_fwd_a <= 1'b0;
      r_mem_fwd_b <= 1'b0;
    end else begin
      r_ex_fwd_a  <= !w_idex_bubble && w_rs_ex_hit;
      r_ex_fwd_b  <= !w_idex_bubble && w_rt_ex_hit;
      r_mem_fwd_a <= !w_idex_bubble && !w_rs_ex_hit && w_rs_mem_hit;
      r_mem_fwd_b <= !w_idex_bubble && !w_rt_ex_hit && w_rt_mem_hit;
    end
  end

  assign o_ex_forward_a  = r_ex_fwd_a;
  assign o_ex_forward_b  = r_ex_fwd_b;
  assign o_mem_forward_a = r_mem_fwd_a;
  assign o_mem_forward_b = r_mem_fwd_b;
  assign o_pc_hold       = w_pc_hold;
  assign o_ifid_hold     = w_pc_hold;
  assign o_idex_bubble   = w_idex_bubble;
  assign o_ifid_flush    = w_ifid_flush;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_pc_hold && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (w_ifid_flush && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: vector table plus short multi-cycle sequences.
module tb_hazard_forward_ctrl;

  localparam int CNT_W = 16;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       regdst, regwr, memtoreg, uses_rt, jump, br;
    logic [7:0] exp;  // {ex_a, ex_b, mem_a, mem_b, pc_hold, ifid_hold, idex_bubble, ifid_flush}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_regdst = 0, id_regwr = 0, id_memtoreg = 0, id_uses_rt = 0, id_jump = 0, ex_br = 0;

  logic ex_a1, ex_b1, mem_a1, mem_b1, pch1, ifh1, bub1, fl1;
  logic ex_a2, ex_b2, mem_a2, mem_b2, pch2, ifh2, bub2, fl2;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] sc1, fc1, sc2, fc2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(CNT_W)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd),
    .i_id_RegDst(id_regdst), .i_id_RegWr(id_regwr), .i_id_MemToReg(id_memtoreg),
    .i_id_uses_rt(id_uses_rt), .i_id_Jump(id_jump), .i_ex_branch_taken(ex_br),
    .o_ex_forward_a(ex_a1), .o_ex_forward_b(ex_b1),
    .o_mem_forward_a(mem_a1), .o_mem_forward_b(mem_b1),
    .o_pc_hold(pch1), .o_ifid_hold(ifh1), .o_idex_bubble(bub1), .o_ifid_flush(fl1)
`ifdef HAZ_PERF_CNT_EN
    , .o_stall_count(sc1), .o_flush_count(fc1)
`endif
  );

  hazard_forward_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(CNT_W)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd),
    .i_id_RegDst(id_regdst), .i_id_RegWr(id_regwr), .i_id_MemToReg(id_memtoreg),
    .i_id_uses_rt(id_uses_rt), .i_id_Jump(id_jump), .i_ex_branch_taken(ex_br),
    .o_ex_forward_a(ex_a2), .o_ex_forward_b(ex_b2),
    .o_mem_forward_a(mem_a2), .o_mem_forward_b(mem_b2),
    .o_pc_hold(pch2), .o_ifid_hold(ifh2), .o_idex_bubble(bub2), .o_ifid_flush(fl2)
`ifdef HAZ_PERF_CNT_EN
    , .o_stall_count(sc2), .o_flush_count(fc2)
`endif
  );

  function automatic vec_t mk(input logic [4:0] rs, rt, rd, input logic regdst, regwr, memtoreg, uses_rt, jump);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd; v.regdst = regdst; v.regwr = regwr;
    v.memtoreg = memtoreg; v.uses_rt = uses_rt; v.jump = jump; v.br = 1'b0; v.exp = '0;
    return v;
  endfunction

  function automatic vec_t i_addi(input logic [4:0] t, s); return mk(s, t, 5'd0, 0, 1, 0, 0, 0); endfunction
  function automatic vec_t i_add(input logic [4:0] d, s, t); return mk(s, t, d, 1, 1, 0, 1, 0); endfunction
  function automatic vec_t i_lw(input logic [4:0] t, s); return mk(s, t, 5'd0, 0, 1, 1, 0, 0); endfunction
  function automatic vec_t i_jr(input logic [4:0] s); return mk(s, 5'd0, 5'd0, 0, 0, 0, 0, 1); endfunction
  function automatic vec_t i_nop(); return mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0); endfunction

  task automatic add(input vec_t v, input logic [7:0] e, input logic br = 1'b0);
    vec_t x;
    x = v; x.exp = e; x.br = br;
    vq.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs1();
    return {ex_a1, ex_b1, mem_a1, mem_b1, pch1, ifh1, bub1, fl1};
  endfunction
  function automatic logic [7:0] outs2();
    return {ex_a2, ex_b2, mem_a2, mem_b2, pch2, ifh2, bub2, fl2};
  endfunction

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_regdst = v.regdst; id_regwr = v.regwr;
    id_memtoreg = v.memtoreg; id_uses_rt = v.uses_rt; id_jump = v.jump; ex_br = v.br;
  endtask

  // One cycle: drive at negedge, compare the selected DUT (0 = none, 1, 2) shortly after.
  task automatic step(input vec_t v, input int dut, input string name);
    @(negedge clk);
    drive(v);
    #1;
    if (dut == 1) chk(name, {24'd0, outs1()}, {24'd0, v.exp});
    else if (dut == 2) chk(name, {24'd0, outs2()}, {24'd0, v.exp});
  endtask

  task automatic run_queue(input int dut, input string tag);
    for (int i = 0; i < vq.size(); i++) step(vq[i], dut, $sformatf("%s%0d", tag, i));
    vq.delete();
  endtask

  initial begin
    // Reset state, with flush-causing inputs active to show they are masked.
    id_jump = 1'b1; ex_br = 1'b1;
    #23;
    chk("rst_outs_dut1", {24'd0, outs1()}, 32'd0);
    chk("rst_outs_dut2", {24'd0, outs2()}, 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rst_stall_cnt", {16'd0, sc1}, 32'd0);
    chk("rst_flush_cnt", {16'd0, fc1}, 32'd0);
`endif
    drive(i_nop());
    @(negedge clk);
    rst_n = 1'b1;

    // Main table, checked on the LOAD_STALL_CYCLES=1 instance.
    add(i_addi(1, 0), 8'b0000_0000);
    add(i_addi(2, 0), 8'b0000_0000);
    add(i_add(1, 1, 2), 8'b0000_0000);
    add(i_nop(), 8'b0110_0000);          // ex_forward_b, mem_forward_a
    add(i_nop(), 8'b0000_0000);
    add(i_addi(7, 0), 8'b0000_0000);
    add(i_addi(7, 0), 8'b0000_0000);
    add(i_add(8, 7, 7), 8'b0000_0000);
    add(i_nop(), 8'b1100_0000);          // EX match wins over MEM on both operands
    add(i_addi(9, 0), 8'b0000_0000);
    add(i_addi(9, 0), 8'b0000_0000);     // rt=9 but not a source
    add(i_nop(), 8'b0000_0000);
    add(i_add(0, 1, 2), 8'b0000_0000);
    add(i_add(3, 0, 0), 8'b0000_0000);   // $0 producer never forwarded
    add(i_nop(), 8'b0000_0000);
    add(i_addi(13, 0), 8'b0000_0000);
    add(i_nop(), 8'b0000_0000);
    add(i_add(15, 0, 13), 8'b0000_0000);
    add(i_add(14, 13, 13), 8'b0001_0000); // producer in WB now: no forward next
    add(i_nop(), 8'b0000_0000);
    add(i_lw(3, 0), 8'b0000_0000);
    add(i_add(5, 3, 0), 8'b0000_1110);   // load-use stall
    add(i_add(5, 3, 0), 8'b0000_0000);
    add(i_nop(), 8'b0010_0000);          // mem_forward_a after the bubble
    add(i_lw(6, 0), 8'b0000_0000);
    add(i_add(7, 6, 0), 8'b0000_0011, 1'b1); // branch beats load-use
    add(i_nop(), 8'b0000_0000);
    add(i_nop(), 8'b0000_0000);
    add(i_addi(4, 0), 8'b0000_0000);
    add(i_jr(0), 8'b0000_0001);          // j: flush one cycle
    add(i_add(16, 4, 4), 8'b0000_0000);
    add(i_nop(), 8'b0011_0000);          // older producer still tracked
    add(i_lw(17, 0), 8'b0000_0000);
    add(i_jr(17), 8'b0000_1110);         // jump held by stall, no flush
    add(i_jr(17), 8'b0000_0001);         // flush once released
    add(i_nop(), 8'b0010_0000);
    add(i_nop(), 8'b0000_0000);
    run_queue(1, "vec");

    // Two-cycle load-use stall, then a branch cancelling the extended stall.
    add(i_nop(), 8'b0);
    add(i_nop(), 8'b0);
    run_queue(0, "pre");
    add(i_lw(3, 0), 8'b0000_0000);
    add(i_add(5, 3, 0), 8'b0000_1110);
    add(i_add(5, 3, 0), 8'b0000_1110);
    add(i_add(5, 3, 0), 8'b0000_0000);
    add(i_nop(), 8'b0000_0000);          // load reached WB: no forward
    add(i_nop(), 8'b0000_0000);
    add(i_lw(3, 0), 8'b0000_0000);
    add(i_add(5, 3, 0), 8'b0000_1110);
    add(i_add(5, 3, 0), 8'b0000_0011, 1'b1);
    add(i_nop(), 8'b0000_0000);
    add(i_nop(), 8'b0000_0000);
    run_queue(2, "ls2_");

    // Reset asserted in the middle of a stall.
    add(i_lw(3, 0), 8'b0000_0000);
    add(i_add(5, 3, 0), 8'b0000_1110);
    run_queue(1, "rs");
    #2;
    rst_n = 1'b0;
    ex_br = 1'b1;
    #1;
    chk("midrst_dut1", {24'd0, outs1()}, 32'd0);
    chk("midrst_dut2", {24'd0, outs2()}, 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_hold_dut1", {24'd0, outs1()}, 32'd0);
    drive(i_nop());
    @(negedge clk);
    rst_n = 1'b1;
`ifdef HAZ_PERF_CNT_EN
    chk("midrst_stall_cnt", {16'd0, sc1}, 32'd0);
    chk("midrst_flush_cnt", {16'd0, fc1}, 32'd0);
    add(i_lw(3, 0), 8'b0);
    add(i_add(5, 3, 0), 8'b0);
    add(i_add(5, 3, 0), 8'b0);
    add(i_nop(), 8'b0);
    add(i_nop(), 8'b0);
    run_queue(0, "perf");
    @(negedge clk);
    #1;
    chk("perf_stall_dut1", {16'd0, sc1}, 32'd1);
    chk("perf_stall_dut2", {16'd0, sc2}, 32'd2);
    chk("perf_flush_dut1", {16'd0, fc1}, 32'd0);
    add(i_jr(0), 8'b0);
    add(i_nop(), 8'b0);
    run_queue(0, "perfj");
    @(negedge clk);
    #1;
    chk("perf_flush_j", {16'd0, fc1}, 32'd1);
`else
    add(i_nop(), 8'b0000_0000);
    add(i_nop(), 8'b0000_0000);
    run_queue(1, "post");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
